// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave bus bundle for irq_aggregator: 3-bit word address,
// 16-bit data, active-low write strobe, registered readdata.
interface irq_aggregator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-input level/edge capture, mask, force, and a
// priority vector. Define IRQ_AGG_SYNC_EN to add a 2-flop input synchroniser.
module irq_aggregator #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_aggregator_if.slave    bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE = 3'd3;
  localparam logic [2:0] ADDR_VECTOR = 3'd4;
  localparam logic [2:0] ADDR_FORCE  = 3'd5;

  logic [NUM_IRQ-1:0] samp;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic               wr;
  logic               wr_status, wr_mask, wr_mode, wr_force;
  logic [NUM_IRQ-1:0] wdata_n;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] frc;
  logic [NUM_IRQ-1:0] active;
  logic [3:0]         vec_idx;
  logic               any_active;
  logic [15:0]        pend_ext, mask_ext, mode_ext, act_ext;
  logic               unused_wdata;

`ifdef IRQ_AGG_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = irq_in;
`endif

  // Bus decode
  assign wr           = bus.chipselect & ~bus.write_n;
  assign wr_status    = wr && (bus.address == ADDR_STATUS);
  assign wr_mask      = wr && (bus.address == ADDR_MASK);
  assign wr_mode      = wr && (bus.address == ADDR_MODE);
  assign wr_force     = wr && (bus.address == ADDR_FORCE);
  assign wdata_n      = bus.writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.writedata;

  assign rise     = samp & ~prev_q;
  assign mode_chg = wr_mode  ? (wdata_n ^ mode_q) : '0;
  assign w1c      = wr_status ? wdata_n : '0;
  assign frc      = wr_force  ? (wdata_n & mode_q) : '0;

  assign mask_d = wr_mask ? wdata_n : mask_q;
  assign mode_d = wr_mode ? wdata_n : mode_q;

  // A mode change wins over everything; in edge mode a set beats a clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pending_d[i] = samp[i];
      end else if (rise[i] || frc[i]) begin
        pending_d[i] = 1'b1;
      end else if (w1c[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  assign active     = pending_q & mask_q;
  assign any_active = |active;
  assign irq_d      = any_active;

  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx = 4'(i);
      end
    end
  end

  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    mode_ext = '0;
    act_ext  = '0;
    pend_ext[NUM_IRQ-1:0] = pending_q;
    mask_ext[NUM_IRQ-1:0] = mask_q;
    mode_ext[NUM_IRQ-1:0] = mode_q;
    act_ext[NUM_IRQ-1:0]  = active;
  end

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_STATUS: rdata_d = pend_ext;
      ADDR_MASK:   rdata_d = mask_ext;
      ADDR_MODE:   rdata_d = mode_ext;
      ADDR_ACTIVE: rdata_d = act_ext;
      ADDR_VECTOR: rdata_d = {any_active, 11'b0, vec_idx};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= samp;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: register-access vector table plus
// directed sequences for latency, edge/clear races, mode changes and reset.
module tb_irq_aggregator;

`ifdef IRQ_AGG_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int NUM_IRQ = 8;

  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;

  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  logic               clk;
  logic               reset_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq;
  int                 n_tests;
  int                 n_fail;
  vec_t               vecs[$];

  irq_aggregator_if bus_if();

  irq_aggregator #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [2:0] addr, input logic [15:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] addr, output logic [15:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    @(negedge clk);
    data              = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(addr, d);
    check16(name, d, exp);
  endtask

  // Number of falling edges until irq reaches target (20 means it never did).
  task automatic wait_irq(input logic target, output int n);
    n = 0;
    while (irq !== target && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] d;

    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    irq_in  = '0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;

    // Reset reads, then force/mask/vector/W1C/mode register behaviour
    for (int a = 0; a < 8; a++)
      vecs.push_back('{OP_RD, 3'(a), 16'h0000, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{OP_WR, 3'd2, 16'h00FF, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_WR, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_WR, 3'd5, 16'h0088, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd0, 16'h0000, 1'b1, 16'h0088, 1'b0});
    vecs.push_back('{OP_RD, 3'd3, 16'h0000, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd5, 16'h0000, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd2, 16'h0000, 1'b1, 16'h00FF, 1'b0});
    vecs.push_back('{OP_WR, 3'd1, 16'hFFFF, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd4, 16'h0000, 1'b1, 16'h8003, 1'b1});
    vecs.push_back('{OP_RD, 3'd1, 16'h0000, 1'b1, 16'h00FF, 1'b1});
    vecs.push_back('{OP_RD, 3'd3, 16'h0000, 1'b1, 16'h0088, 1'b1});
    vecs.push_back('{OP_RD, 3'd6, 16'h0000, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{OP_WR, 3'd0, 16'h0008, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD, 3'd4, 16'h0000, 1'b1, 16'h8007, 1'b1});
    vecs.push_back('{OP_WR, 3'd6, 16'hFFFF, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD, 3'd0, 16'h0000, 1'b1, 16'h0080, 1'b1});
    vecs.push_back('{OP_WR, 3'd0, 16'h0080, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD, 3'd4, 16'h0000, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{OP_WR, 3'd2, 16'h00FE, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_WR, 3'd5, 16'h0003, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD, 3'd0, 16'h0000, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{OP_WR, 3'd2, 16'h00FC, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0});

    repeat (2) @(negedge clk);
    check_int("reset irq", int'(irq), 0);
    check16("reset readdata", bus_if.readdata, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      bus_if.address    = vecs[i].addr;
      bus_if.writedata  = vecs[i].wdata;
      bus_if.chipselect = (vecs[i].op != OP_IDLE);
      bus_if.write_n    = (vecs[i].op != OP_WR);
      @(negedge clk);
      if (vecs[i].chk_rd)
        check16($sformatf("vec%0d readdata", i), bus_if.readdata, vecs[i].exp_rd);
      check_int($sformatf("vec%0d irq", i), int'(irq), int'(vecs[i].exp_irq));
    end
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;

    // Level bit 0: latency, status/vector, W1C ignored while high
    bus_wr(3'd2, 16'h0000);
    bus_wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    wait_irq(1'b1, n);
    check_int("level rise latency", n, 2 + SYNC_LAT);
    rd_check("level status", 3'd0, 16'h0001);
    rd_check("level vector", 3'd4, 16'h8000);
    rd_check("level active", 3'd3, 16'h0001);
    bus_wr(3'd0, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      check_int($sformatf("level w1c irq hold %0d", k), int'(irq), 1);
      @(negedge clk);
    end
    rd_check("level status after w1c", 3'd0, 16'h0001);
    irq_in[0] = 1'b0;
    wait_irq(1'b0, n);
    check_int("level fall latency", n, 2 + SYNC_LAT);

    // Edge bit 2: one-cycle pulse is latched, W1C clears it
    bus_wr(3'd2, 16'h0004);
    bus_wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    @(negedge clk);
    irq_in[2] = 1'b0;
    repeat (3 + SYNC_LAT) @(negedge clk);
    rd_check("edge pulse status", 3'd0, 16'h0004);
    check_int("edge pulse irq", int'(irq), 1);
    bus_wr(3'd0, 16'h0004);
    check_int("edge w1c irq same edge", int'(irq), 1);
    @(negedge clk);
    check_int("edge w1c irq next edge", int'(irq), 0);
    rd_check("edge status cleared", 3'd0, 16'h0000);

    // New rising edge coincides with W1C: the set wins
    irq_in[2] = 1'b1;
    @(negedge clk);
    irq_in[2] = 1'b0;
    repeat (3 + SYNC_LAT) @(negedge clk);
    rd_check("race pre status", 3'd0, 16'h0004);
    irq_in[2] = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    bus_wr(3'd0, 16'h0004);
    irq_in[2] = 1'b0;
    repeat (3 + SYNC_LAT) @(negedge clk);
    rd_check("race status kept", 3'd0, 16'h0004);
    bus_wr(3'd0, 16'h0004);
    rd_check("race status cleared", 3'd0, 16'h0000);

    // Mode change clears pending; held-high input gives no edge afterwards
    bus_wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    repeat (3 + SYNC_LAT) @(negedge clk);
    rd_check("modechg pre status", 3'd0, 16'h0001);
    bus_wr(3'd2, 16'h0001);
    repeat (2) @(negedge clk);
    rd_check("modechg cleared", 3'd0, 16'h0000);
    irq_in[0] = 1'b0;
    repeat (3 + SYNC_LAT) @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (3 + SYNC_LAT) @(negedge clk);
    rd_check("modechg new edge", 3'd0, 16'h0001);
    check_int("modechg irq", int'(irq), 1);

    // Asynchronous reset while pending: everything drops at once
    check16("pre-reset readdata", bus_if.readdata, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check_int("async reset irq", int'(irq), 0);
    check16("async reset readdata", bus_if.readdata, 16'h0000);
    irq_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_check("post-reset status", 3'd0, 16'h0000);
    rd_check("post-reset mask", 3'd1, 16'h0000);
    rd_check("post-reset mode", 3'd2, 16'h0000);
    check_int("post-reset irq", int'(irq), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_aggregator.md
Name: irq_aggregator

Overview:
- Avalon-MM slave that gathers the single-bit interrupt outputs of the interval timer and sibling peripherals into one CPU interrupt.
- Sits directly downstream of the timer: consumes the timer's irq as one of its inputs.
- Per-input level or rising-edge capture, enable mask, software force, and a priority-encoded vector register so the ISR reads one word to find its source.
- 16-bit data bus and 1-cycle registered read latency, matching the other peripheral slaves on the Nios II system bus.

Parameters:
NUM_IRQ, 8, number of interrupt inputs; legal range 1..16; unused register bits read 0.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  16  write data
irq_in  input  NUM_IRQ  peripheral interrupt lines; bit 0 = timer
readdata  output  16  registered read data
irq  output  1  aggregated interrupt to CPU

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Reads need no strobe; readdata <= mux(address) every clk.
- Address map:
  - 0 STATUS (R/W1C): pending[NUM_IRQ-1:0].
  - 1 MASK (R/W): enable bits.
  - 2 MODE (R/W): 1 = rising-edge capture, 0 = level.
  - 3 ACTIVE (RO): pending & mask.
  - 4 VECTOR (RO): bit15 = any active; [3:0] = index of lowest-numbered active bit; all 0 when none active.
  - 5 FORCE (WO): write-1 sets pending on edge-mode bits; reads 0.
  - 6–7: read 0; writes ignored.
- Reset: pending, mask, mode, prev, readdata and irq all 0.
- Sampling:
  - s = irq_in (or the synchronised copy, see Optional Feature).
  - prev <= s every clk; edge = s & ~prev.
- Level-mode bit i: pending[i] <= s[i] every clk. W1C and FORCE have no effect on it.
- Edge-mode bit i, next-state priority, highest first:
  1. MODE write changing bit i -> 0.
  2. edge[i] or FORCE[i] -> 1.
  3. STATUS W1C bit i -> 0.
  4. Otherwise hold.
  - A set beats a simultaneous clear, so no edge is lost.
- MODE write: any bit whose mode changes has its pending cleared that cycle. From the next cycle the bit follows the new mode's rules.
- Because prev resets to 0, an input already high when reset_n deasserts registers a rising edge on the first clk.
- irq <= |(pending & mask), registered.
  - Latency without sync: irq_in rise before edge k -> pending at edge k -> irq at edge k+1.
  - Latency with sync: 2 cycles more.
- MASK write takes effect on irq at the following edge. Pending is retained while masked.
- VECTOR, ACTIVE and STATUS reflect register state at the read cycle's edge; readdata is valid one cycle later.
- Reset asserted mid-operation clears everything immediately (async). No pending survives.
- NUM_IRQ < 16: writedata bits above NUM_IRQ-1 are ignored; irq_in has no such bits.

Optional Feature:
- Macro: IRQ_AGG_SYNC_EN.
- Defined: each irq_in bit passes through a 2-flop synchroniser (reset 0) before prev/edge logic. This supports sources in other clock domains (e.g. D8M camera interface). Adds 2 cycles of input latency.
- Undefined: irq_in is used directly. All sources must be clk-synchronous.

Test Plan:
1. Reset, read addresses 0–5 -> all read 0x0000; irq = 0.
2. MODE=0x0000, MASK=0x0001; hold irq_in[0]=1 -> irq = 1 two edges after the rise; STATUS = 0x0001; VECTOR = 0x8000. Drop irq_in[0] -> irq = 0 two edges later. A W1C to STATUS has no effect while the input is high.
3. MODE=0x0004, MASK=0x0004; 1-cycle pulse on irq_in[2] -> STATUS = 0x0004 latched after the pulse ends. Write 0x0004 to STATUS -> pending clears; irq = 0 the following edge.
4. Edge bit 2 pending; write STATUS W1C 0x0004 in the same cycle as a new rising edge on irq_in[2] -> STATUS remains 0x0004.
5. MODE=0x00FF, MASK=0x0000; FORCE write 0x0088 -> STATUS = 0x0088, irq = 0, ACTIVE = 0. Then MASK=0x00FF -> irq = 1; VECTOR = 0x8003.
6. With IRQ_AGG_SYNC_EN defined, level bit 0: rise on irq_in[0] -> irq = 1 four edges later. Assert reset_n low mid-pending -> irq and readdata go to 0 immediately.
